// File: rtl/imem_fetch_unit.sv
// Instruction memory for the MIPS core: loads a program word by word,
// then answers each byte-address PC with a registered instruction.
module imem_fetch_unit #(
  parameter int          DEPTH    = 64,
  parameter int          IDX_W    = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic [31:0]      pc_in,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fetch_err,
  output logic             fetch_stall,
  output logic [IDX_W:0]   load_count
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W:0]   ptr;
  logic [31:0]      mem [DEPTH];
  logic             full;
  logic             accept;
  logic             hit;
  logic [IDX_W-1:0] idx;

  assign full        = ptr == FULL;
  assign load_ready  = (state == LOAD) && !full && !load_start;
  assign accept      = load_valid && load_ready;
  assign fetch_stall = state != RUN;
  assign idx         = pc_in[IDX_W+1:2];
  // Full 30-bit word address is compared so aliased high PCs miss.
  assign hit = (pc_in[1:0] == 2'b00) &&
               ({2'b00, pc_in[31:2]} < 32'(load_count));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load_start) state_nx = LOAD;
      LOAD: begin
        if (load_start)
          state_nx = LOAD;
        else if (full)
          state_nx = RUN;
        else if (accept && (load_last || ptr == LAST))
          state_nx = RUN;
      end
      RUN:  if (load_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      load_count  <= '0;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (load_start) begin
      ptr         <= '0;
      load_count  <= '0;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (accept) begin
      ptr         <= ptr + 1'b1;
      load_count  <= ptr + 1'b1;
    end else if (state == RUN) begin
      instr_valid <= 1'b1;
      instr       <= hit ? mem[idx] : NOP_WORD;
      fetch_err   <= !hit;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[ptr[IDX_W-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a word-array model predicts
// every RUN-cycle fetch; a monitor pops and compares each valid output.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start, load_valid, load_last;
  logic [31:0] load_data, pc_in;
  logic        load_ready, instr_valid, fetch_err, fetch_stall;
  logic [31:0] instr;
  logic [6:0]  load_count;

  always #5 clk = ~clk;

  imem_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .pc_in(pc_in),
    .instr(instr), .instr_valid(instr_valid),
    .fetch_err(fetch_err), .fetch_stall(fetch_stall),
    .load_count(load_count)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rmem [64];
  int          rcnt = 0;
  int          rmode = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid output must match the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (instr_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty got instr %h want none at %0t", instr, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("instr", instr, mon_e.w);
        chk("fetch_err", 32'(fetch_err), 32'(mon_e.e));
      end
    end else begin
      chk("idle_instr", instr, 32'h0);
      chk("idle_err", 32'(fetch_err), 32'h0);
    end
  end

  task automatic step();
    exp_t x;
    #1;
    chk("load_ready", 32'(load_ready),
        32'(rmode == 1 && rcnt < 64 && !load_start));
    chk("fetch_stall", 32'(fetch_stall), 32'(rmode != 2));
    chk("load_count", 32'(load_count), 32'(rcnt));
    case (rmode)
      0: if (load_start) begin rmode = 1; rcnt = 0; end
      1: begin
        if (load_start) rcnt = 0;
        else if (load_valid && rcnt < 64) begin
          rmem[rcnt] = load_data;
          rcnt++;
          if (load_last || rcnt == 64) rmode = 2;
        end
      end
      default: begin
        if (load_start) begin
          rmode = 1;
          rcnt = 0;
        end else begin
          if (pc_in % 4 == 0 && (pc_in / 4) < 32'(rcnt)) begin
            x.w = rmem[pc_in / 4];
            x.e = 1'b0;
          end else begin
            x.w = 32'h0;
            x.e = 1'b1;
          end
          sbq.push_back(x);
        end
      end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    step();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    pc_in = pc;
    step();
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_err"}, 32'(fetch_err), 32'h0);
    chk({tag, "_ready"}, 32'(load_ready), 32'h0);
    chk({tag, "_stall"}, 32'(fetch_stall), 32'h1);
    chk({tag, "_count"}, 32'(load_count), 32'h0);
  endtask

  logic [31:0] prog [5] = '{32'h01098020, 32'h014B8822, 32'h018D9024,
                            32'h01CF9825, 32'h0319A02A};

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sel;
    logic [31:0] pc;
    load_start = 0; load_valid = 0; load_last = 0;
    load_data = 0; pc_in = 0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // Five-word program, then fetches.
    pulse_start();
    for (int i = 0; i < 5; i++) beat(prog[i], i == 4);
    step();
    chk("tp1_count", 32'(load_count), 32'd5);
    fetch(0); fetch(4); fetch(16);
    fetch(2); fetch(20); fetch(8);
    step();

    // Overflow: 70 beats with no last, only 64 stored.
    pulse_start();
    for (int i = 0; i < 70; i++) beat($urandom, 1'b0);
    chk("tp4_count", 32'(load_count), 32'd64);
    fetch(252); fetch(256); fetch(32'h4000_0000);
    step();

    // Reload from RUN with a 2-word program.
    pulse_start();
    beat(32'hAAAA_0001, 1'b0);
    beat(32'hAAAA_0002, 1'b1);
    step();
    fetch(8); fetch(0); fetch(4);
    step();

    // Asynchronous reset mid-load.
    pulse_start();
    for (int i = 0; i < 3; i++) beat($urandom, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("arst");
    rmode = 0;
    rcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random programs with gaps and random fetches.
    for (int r = 0; r < 8; r++) begin
      pulse_start();
      n = $urandom_range(1, 64);
      for (int k = 0; k < 1000 && rmode == 1; k++) begin
        load_valid = ($urandom % 4) != 0;
        load_data = $urandom;
        load_last = (rcnt == n - 1);
        pc_in = $urandom;
        step();
      end
      load_valid = 0;
      load_last = 0;
      for (int k = 0; k < 40; k++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: pc = 32'($urandom_range(0, rcnt - 1)) << 2;
          1: pc = 32'($urandom_range(rcnt, 63)) << 2;
          2: pc = (32'($urandom_range(0, rcnt - 1)) << 2) |
                  32'($urandom_range(1, 3));
          default: pc = $urandom;
        endcase
        fetch(pc);
      end
    end

    step();
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Instruction-memory responder for mips_processor.
- Loads a program over a word-serial valid/ready port.
- Then answers every processor byte-address PC with a registered 32-bit instruction, one cycle later.
- Replaces ad-hoc instruction arrays in benches and sits between the program source and the processor's instr input.

Parameters:
DEPTH, 64, number of 32-bit instruction words stored
IDX_W, 6, word-index width, equal to log2(DEPTH)
NOP_WORD, 32'h00000000, instruction returned for invalid fetches and while not running

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  single-cycle pulse; enters LOAD and clears the write pointer
load_valid  input  1  load beat valid
load_data  input  32  instruction word for the current beat
load_last  input  1  marks the final beat of the program
load_ready  output  1  unit accepts a beat this cycle
pc_in  input  32  byte address, driven from processor pc_out
instr  output  32  fetched instruction, registered
instr_valid  output  1  instr holds a real fetch result
fetch_err  output  1  last fetch was misaligned or beyond the loaded program
fetch_stall  output  1  processor must hold its PC, high when not in RUN
load_count  output  IDX_W+1  number of words loaded

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE.
  - instr=NOP_WORD, instr_valid=0, fetch_err=0, load_ready=0, fetch_stall=1, load_count=0, write pointer=0.
  - Memory array is not cleared. Words at or above load_count are never returned.
- States: IDLE, LOAD, RUN.
- IDLE:
  - Outputs: load_ready=0, fetch_stall=1, instr=NOP_WORD, instr_valid=0.
  - load_start -> LOAD.
- LOAD:
  - fetch_stall=1, instr=NOP_WORD, instr_valid=0.
  - load_ready=1 except when ptr==DEPTH or load_start is high in that cycle. load_ready is combinational from state/ptr/load_start.
  - Beat accepted when load_valid & load_ready. On accept: mem[ptr]<=load_data, ptr<=ptr+1, load_count<=ptr+1.
  - Accepted beat with load_last=1 -> RUN next cycle.
  - ptr reaching DEPTH without load_last -> RUN next cycle. No wrap; excess beats are not accepted.
  - load_start while in LOAD: ptr<=0, load_count<=0, stay in LOAD. A load_valid in the same cycle is not accepted.
  - load_last with load_valid low is ignored.
- RUN:
  - load_ready=0, fetch_stall=0.
  - Every rising edge samples pc_in: idx=pc_in[IDX_W+1:2]. Latency is exactly 1 cycle.
  - Valid fetch when pc_in[1:0]==0 and pc_in[31:2] < load_count. Then instr<=mem[idx], fetch_err<=0.
  - Otherwise instr<=NOP_WORD, fetch_err<=1.
  - instr_valid<=1 on every RUN cycle.
  - load_start in RUN -> LOAD. On that edge: instr<=NOP_WORD, instr_valid<=0, fetch_err<=0, ptr<=0, load_count<=0.
- Reset mid-LOAD: load_count returns to 0. The partial program is discarded logically.
- Zero-length program (no beats before a reset) is not possible. RUN is only entered after at least one accepted beat.
- Memory reads use registered output only; no combinational path from pc_in to instr.

Test Plan:
1. Reset, load_start, then 5 beats 01098020, 014B8822, 018D9024, 01CF9825, 0319A02A (last on beat 5) -> load_count=5, RUN one cycle after beat 5, fetch_stall falls.
2. In RUN, drive pc_in=0,4,16 on successive edges -> instr=01098020, 014B8822, 0319A02A one cycle later each; instr_valid=1, fetch_err=0.
3. pc_in=2, then pc_in=20 with 5 words loaded -> instr=00000000, fetch_err=1 both cycles. pc_in=8 next -> 018D9024, fetch_err=0.
4. Stream 70 beats without load_last -> exactly 64 accepted. load_ready low after beat 64, RUN next cycle. pc_in=252 returns beat 64's word.
5. load_start pulse in RUN, then 2 beats with last -> instr_valid=0 during LOAD, load_count=2. Afterwards pc_in=8 gives NOP with fetch_err=1.
6. rst_n low mid-LOAD after 3 beats, asynchronously between edges -> all outputs at reset values immediately, state IDLE, load_count=0.
